// File: rtl/puf_pkg.sv
// Shared types and default constants for the ring-oscillator PUF response generator.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } state_t;

    localparam int DEF_RESP_BITS     = 8;
    localparam int DEF_WINDOW_CYCLES = 1024;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one asynchronous oscillator output, detects rising edges and
// counts them into a saturating counter while enabled.
module ro_edge_counter
    import puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;
    logic rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end
        return val + 1'b1;
    endfunction

    // p0/p1: two-flop synchronizer, p2: previous synchronized level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= ro;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && rise) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/puf_resp_gen.sv
// Ring-oscillator PUF: for each challenge, races oscillator A against B over a
// fixed window and records which one produced more edges.
module puf_resp_gen
    import puf_pkg::*;
#(
    parameter int RESP_BITS     = DEF_RESP_BITS,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         ro_a,
    input  logic                         ro_b,
    output logic                         ro_en,
    output logic [$clog2(RESP_BITS)-1:0] challenge,
    output logic                         busy,
    output logic                         valid,
    output logic [RESP_BITS-1:0]         response
);

    localparam int IDX_W   = $clog2(RESP_BITS);
    localparam int MAX_CYC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RESP_BITS - 1);
    localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_END = TMR_W'(WINDOW_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    index;
    logic [TMR_W-1:0]    tmr;
    logic [RESP_BITS-1:0] resp_q;
    logic [CNT_W-1:0]    cnt_a;
    logic [CNT_W-1:0]    cnt_b;
    logic                settle_done;
    logic                window_done;
    logic                last_bit;
    logic                cnt_clear;
    logic                cnt_en;

    assign settle_done = (tmr == SETTLE_END);
    assign window_done = (tmr == WINDOW_END);
    assign last_bit    = (index == LAST_IDX);

    // Counters are cleared on the last settle cycle so the window starts from zero.
    assign cnt_clear = (state == SETTLE) && settle_done;
    assign cnt_en    = (state == COUNT);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .ro    (ro_a),
        .clear (cnt_clear),
        .en    (cnt_en),
        .cnt   (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .ro    (ro_b),
        .clear (cnt_clear),
        .en    (cnt_en),
        .cnt   (cnt_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_done) state_next = COUNT;
            COUNT:   if (window_done) state_next = COMPARE;
            COMPARE: state_next = last_bit ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index  <= '0;
            tmr    <= '0;
            resp_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        index  <= '0;
                        tmr    <= '0;
                        resp_q <= '0;
                    end
                end
                SETTLE:  tmr <= settle_done ? '0 : tmr + 1'b1;
                COUNT:   tmr <= window_done ? '0 : tmr + 1'b1;
                COMPARE: begin
                    // Strictly greater: a tie resolves to 0.
                    resp_q[index] <= (cnt_a > cnt_b);
                    tmr           <= '0;
                    if (!last_bit) begin
                        index <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ro_en     = (state == SETTLE) || (state == COUNT);
    assign busy      = (state != IDLE);
    assign valid     = (state == DONE);
    assign challenge = index;
    assign response  = resp_q;

endmodule

// File: tb/tb_puf_resp_gen.sv
// Bench for puf_resp_gen: vector table of oscillator periods per challenge,
// scoreboard queues popped on valid, plus reset and start-handling sequences.
module tb_puf_resp_gen;

    localparam int RB  = 4;
    localparam int WC  = 64;
    localparam int SC  = 4;
    localparam int LAT = RB * (SC + WC + 1) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;

    logic       ro_en1, busy1, valid1;
    logic [1:0] ch1;
    logic [3:0] resp1;
    logic       ro_en2, busy2, valid2;
    logic [1:0] ch2;
    logic [3:0] resp2;

    puf_resp_gen #(.RESP_BITS(RB), .WINDOW_CYCLES(WC), .SETTLE_CYCLES(SC), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .ro_en(ro_en1), .challenge(ch1), .busy(busy1), .valid(valid1), .response(resp1)
    );

    puf_resp_gen #(.RESP_BITS(RB), .WINDOW_CYCLES(WC), .SETTLE_CYCLES(SC), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .ro_en(ro_en2), .challenge(ch2), .busy(busy2), .valid(valid2), .response(resp2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0] pa;
        logic [3:0][3:0] pb;
        logic            tie;
        logic [3:0]      exp;
        logic [3:0]      exp_s;
    } vec_t;

    typedef struct {
        logic [3:0] resp;
        int         s;
    } sb_t;

    vec_t vecs[4];
    vec_t cfg;
    sb_t  q1[$];
    sb_t  q2[$];
    sb_t  e1, e2;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   cmp1 = 0;
    logic prev_en1 = 1'b0;
    int   ph_a = 0, ph_b = 0;
    int   gen_pa, gen_pb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator model: per-challenge periods in clk cycles, changing at negedge.
    always @(negedge clk) begin
        gen_pa = int'(cfg.pa[ch1]);
        gen_pb = int'(cfg.pb[ch1]);
        ph_a = (ph_a + 1) % gen_pa;
        ro_a = (ph_a < gen_pa / 2);
        if (cfg.tie) begin
            ro_b = ro_a;
        end else begin
            ph_b = (ph_b + 1) % gen_pb;
            ro_b = (ph_b < gen_pb / 2);
        end
    end

    // Output monitor and scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cmp1 = 0;
        end else begin
            if (busy1 && prev_en1 && !ro_en1) begin
                chk("challenge_order", 32'(ch1), 32'(cmp1));
                cmp1++;
            end
            if (valid1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: response=%0h expected no valid", resp1);
                end else begin
                    e1 = q1.pop_front();
                    chk("response", 32'(resp1), 32'(e1.resp));
                    chk("valid_latency", 32'(cyc - e1.s), 32'(LAT));
                    chk("bits_compared", 32'(cmp1), 32'(RB));
                end
                cmp1 = 0;
                done_cnt++;
            end
            if (valid2) begin
                if (q2.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid_sat: response=%0h expected no valid", resp2);
                end else begin
                    e2 = q2.pop_front();
                    chk("response_sat", 32'(resp2), 32'(e2.resp));
                end
            end
        end
        prev_en1 = ro_en1;
    end

    task automatic run_vec(input int i, input bit noise);
        int s;
        int d0;
        @(negedge clk);
        cfg   = vecs[i];
        start = 1'b1;
        s     = cyc;
        d0    = done_cnt;
        q1.push_back('{resp: vecs[i].exp, s: s});
        q2.push_back('{resp: vecs[i].exp_s, s: s});
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 400 && done_cnt == d0; k++) begin
            @(negedge clk);
            if (noise && done_cnt == d0 && (cyc - s) < 250) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: vector %0d got no valid, required valid within 400 cycles", i);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int d0;

        vecs[0] = '{pa: {4'd4, 4'd4, 4'd4, 4'd4}, pb: {4'd6, 4'd6, 4'd6, 4'd6}, tie: 1'b0, exp: 4'b1111, exp_s: 4'b1111};
        vecs[1] = '{pa: {4'd4, 4'd4, 4'd4, 4'd4}, pb: {4'd4, 4'd4, 4'd4, 4'd4}, tie: 1'b1, exp: 4'b0000, exp_s: 4'b0000};
        vecs[2] = '{pa: {4'd4, 4'd6, 4'd4, 4'd6}, pb: {4'd6, 4'd4, 4'd6, 4'd4}, tie: 1'b0, exp: 4'b1010, exp_s: 4'b1010};
        vecs[3] = '{pa: {4'd2, 4'd2, 4'd2, 4'd2}, pb: {4'd8, 4'd8, 4'd8, 4'd8}, tie: 1'b0, exp: 4'b1111, exp_s: 4'b1111};
        cfg = vecs[0];

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ro_en", 32'(ro_en1), 32'd0);
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_challenge", 32'(ch1), 32'd0);
        chk("rst_response", 32'(resp1), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_vec(i, 1'b0);
        end

        // Reset in the middle of the counting window of bit 2, with start also high
        @(negedge clk);
        cfg   = vecs[0];
        start = 1'b1;
        s     = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (159) @(negedge clk);
        chk("mid_challenge", 32'(ch1), 32'd2);
        chk("mid_ro_en", 32'(ro_en1), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_ro_en", 32'(ro_en1), 32'd0);
        chk("abort_response", 32'(resp1), 32'd0);
        chk("abort_challenge", 32'(ch1), 32'd0);
        chk("abort_busy_sat", 32'(busy2), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_idle", 32'(busy1), 32'd0);

        run_vec(0, 1'b0);

        // Start held high: exactly one run per IDLE entry
        @(negedge clk);
        cfg   = vecs[0];
        start = 1'b1;
        s     = cyc;
        d0    = done_cnt;
        q1.push_back('{resp: 4'b1111, s: s});
        q2.push_back('{resp: 4'b1111, s: s});
        q1.push_back('{resp: 4'b1111, s: s + LAT + 1});
        q2.push_back('{resp: 4'b1111, s: s + LAT + 1});
        for (int k = 0; k < 800 && done_cnt < d0 + 2; k++) begin
            @(negedge clk);
        end
        start = 1'b0;
        if (done_cnt < d0 + 2) begin
            checks++;
            failures++;
            $display("FAIL held_start_timeout: runs done %0d, required 2", done_cnt - d0);
        end
        repeat (6) @(negedge clk);
        chk("held_start_stops", 32'(busy1), 32'd0);

        // Start pulses while busy must not disturb the run
        run_vec(2, 1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(q1.size()), 32'd0);
        chk("scoreboard_empty_sat", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
